opr_sequencer: RTL

Instruction sequencer for the OPR operand router. Fetches 1- or 2-byte instructions from a synchronous-read instruction memory and latches the operand byte into MIDR. Drives the OPR `select` code for exactly the execute window, and handshakes each routed operand with the downstream datapath. Owns the program counter, including jump loads via the `opr_pc` route.

---
 rtl/opr_sequencer_pkg.sv | 45 ++++
 rtl/opr_decode.sv | 45 ++++
 rtl/opr_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/opr_sequencer_pkg.sv
// Shared constants and types for the OPR instruction sequencer.
package opr_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned SEL_W  = 3;

    // Opcodes
    localparam logic [DATA_W-1:0] OP_NOP     = 8'h00;
    localparam logic [DATA_W-1:0] OP_AWM     = 8'h01;
    localparam logic [DATA_W-1:0] OP_ACI_AWM = 8'h02;
    localparam logic [DATA_W-1:0] OP_INC     = 8'h03;
    localparam logic [DATA_W-1:0] OP_DEC     = 8'h04;
    localparam logic [DATA_W-1:0] OP_JMP     = 8'h05;
    localparam logic [DATA_W-1:0] OP_RST     = 8'h06;
    localparam logic [DATA_W-1:0] OP_HALT    = 8'hFF;

    // OPR select codes
    localparam logic [SEL_W-1:0] SEL_NONE    = 3'd0;
    localparam logic [SEL_W-1:0] SEL_AWM     = 3'd1;
    localparam logic [SEL_W-1:0] SEL_ACI_AWM = 3'd2;
    localparam logic [SEL_W-1:0] SEL_INC     = 3'd3;
    localparam logic [SEL_W-1:0] SEL_DEC     = 3'd4;
    localparam logic [SEL_W-1:0] SEL_PC      = 3'd5;
    localparam logic [SEL_W-1:0] SEL_RST     = 3'd6;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_ARG    = 3'd2,
        ST_LOAD   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Decoded view of one opcode byte
    typedef struct packed {
        logic             has_arg;
        logic [SEL_W-1:0] sel;
        logic             is_jump;
        logic             is_halt;
        logic             illegal;
    } dec_t;

endpackage

// File: rtl/opr_decode.sv
// Combinational opcode decoder for the OPR sequencer.
module opr_decode
    import opr_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] opcode,
    output dec_t              dec_c
);

    // Map an opcode byte to its operand/route/control attributes
    always_comb begin
        dec_c     = '0;
        dec_c.sel = SEL_NONE;
        case (opcode)
            OP_NOP: ;
            OP_AWM: begin
                dec_c.has_arg = 1'b1;
                dec_c.sel     = SEL_AWM;
            end
            OP_ACI_AWM: begin
                dec_c.has_arg = 1'b1;
                dec_c.sel     = SEL_ACI_AWM;
            end
            OP_INC: begin
                dec_c.has_arg = 1'b1;
                dec_c.sel     = SEL_INC;
            end
            OP_DEC: begin
                dec_c.has_arg = 1'b1;
                dec_c.sel     = SEL_DEC;
            end
            OP_JMP: begin
                dec_c.has_arg = 1'b1;
                dec_c.sel     = SEL_PC;
                dec_c.is_jump = 1'b1;
            end
            OP_RST: begin
                dec_c.has_arg = 1'b1;
                dec_c.sel     = SEL_RST;
            end
            OP_HALT: dec_c.is_halt = 1'b1;
            default: dec_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/opr_sequencer.sv
// Instruction sequencer: fetches 1/2-byte instructions, drives the OPR select
// for the execute window only, and owns the program counter.
module opr_sequencer
    import opr_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] midr,
    output logic [SEL_W-1:0]  opr_sel,
    output logic              exec_valid,
    input  logic              exec_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    state_t           state;
    dec_t             dec_c;
    logic [SEL_W-1:0] sel_q;
    logic             jump_q;

    opr_decode u_decode (
        .opcode (imem_data),
        .dec_c  (dec_c)
    );

    // Memory strobe must land in the FETCH/ARG cycle itself so data returns next cycle
    assign imem_rd_en = ((state == ST_FETCH) && run) || (state == ST_ARG);
    assign imem_addr  = pc;

    // Sequencer FSM with PC, MIDR and route outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= '0;
            midr       <= '0;
            opr_sel    <= SEL_NONE;
            exec_valid <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            sel_q      <= SEL_NONE;
            jump_q     <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (run) begin
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    pc     <= pc + ADDR_W'(1);
                    sel_q  <= dec_c.sel;
                    jump_q <= dec_c.is_jump;
                    if (dec_c.illegal) begin
                        illegal <= 1'b1;
                    end
                    if (dec_c.is_halt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (dec_c.has_arg) begin
                        state <= ST_ARG;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_ARG: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    midr       <= imem_data;
                    pc         <= pc + ADDR_W'(1);
                    opr_sel    <= sel_q;
                    exec_valid <= 1'b1;
                    state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (exec_ready) begin
                        opr_sel    <= SEL_NONE;
                        exec_valid <= 1'b0;
                        if (jump_q) begin
                            pc <= midr;
                        end
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: ;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
